calc_driver: RTL
================

CALC_DRIVER -- requirements
Module: calc_driver

Interface
REQ-001 Parameter TIMEOUT, default 15: number of WAIT cycles without calc_done before the operation is abandoned.
REQ-002 clk  input  1  single system clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  input  1  command request from the host.
REQ-005 cmd_ready  output  1  the block accepts a command this cycle.
REQ-006 cmd_f  input  3  operation select passed to the calculator.
REQ-007 cmd_x, cmd_y  input  4 each  operands.
REQ-008 calc_go  output  1  start pulse to the calculator.
REQ-009 calc_f  output  3  operation select to the calculator.
REQ-010 calc_x, calc_y  output  4 each  operands to the calculator.
REQ-011 calc_done  input  1  calculator completion flag.
REQ-012 calc_error  input  1  calculator error flag, valid with calc_done.
REQ-013 calc_out_h, calc_out_l  input  4 each  calculator result nibbles, valid with calc_done.
REQ-014 rsp_valid  output  1  response FIFO is not empty.
REQ-015 rsp_ready  input  1  host consumes the head response.
REQ-016 rsp_data  output  8  head response, {out_h,out_l}.
REQ-017 rsp_error, rsp_timeout  output  1 each  head response flags.
REQ-018 busy  output  1  high when state is not IDLE.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and STORE.
REQ-020 In IDLE, cmd_ready SHALL equal (FIFO count < 4); cmd_ready SHALL be 0 in every other state.
REQ-021 On cmd_valid & cmd_ready, the block SHALL register cmd_x, cmd_y and cmd_f into calc_x, calc_y and calc_f, and SHALL then enter ISSUE.
REQ-022 calc_x, calc_y and calc_f SHALL stay stable from the accept edge until the next accept, and SHALL hold their last values while idle.
REQ-023 In ISSUE, calc_go SHALL be 1 for exactly one cycle; the timer SHALL clear to 0; the next state SHALL be WAIT. calc_go SHALL be 0 in every other state.
REQ-024 In WAIT, if calc_done=1, the block SHALL capture {calc_out_h,calc_out_l} and calc_error, set timeout to 0, and enter STORE.
REQ-025 In WAIT, if calc_done=0, the timer SHALL increment; when timer==TIMEOUT with no done, the block SHALL capture data 8'h00, error=1, timeout=1, and enter STORE.
REQ-026 If calc_done=1 in the same cycle the timeout is reached, done SHALL win.
REQ-027 calc_done SHALL be ignored outside WAIT.
REQ-028 In STORE, the block SHALL push the captured 10-bit entry {timeout,error,data} into the FIFO and then enter IDLE.
REQ-029 The FIFO SHALL be 4 entries deep with wrap-around pointers and a 3-bit count; rsp_* outputs SHALL show the head entry.
REQ-030 A pop SHALL occur on rsp_valid & rsp_ready; a simultaneous push and pop SHALL leave count unchanged; a pop on empty SHALL be ignored.
REQ-031 The FIFO cannot overflow, because acceptance is gated on count<4 and only STORE pushes.
REQ-032 With immediate done, timing SHALL be: accept at cycle 0, calc_go at cycle 1, done sampled at cycle 2, STORE at cycle 3, rsp_valid=1 at cycle 4 (from an empty FIFO). The next command is accepted no earlier than cycle 4.
REQ-033 Commands SHALL be serviced strictly in order; responses SHALL leave in acceptance order.

Reset
REQ-034 While rst=0, the following SHALL hold immediately, independent of clk: state IDLE, timer 0, FIFO empty, calc_go=0, calc_x=calc_y=0, calc_f=0, rsp_valid=0, rsp_data=0, rsp_error=0, rsp_timeout=0, busy=0, cmd_ready=0.
REQ-035 Reset during ISSUE or WAIT SHALL discard the in-flight operation; no response is produced for it, and a calc_done arriving after reset SHALL be ignored.
REQ-036 After rst rises, cmd_ready SHALL be 1 on the first clock edge.

Verification
REQ-037 x=4'hA, y=4'h3, f=3'd0, calc model returns done with {out_h,out_l}=8'h0D at cycle 2 -> calc_go high only at cycle 1; rsp_valid at cycle 4; rsp_data=8'h0D, rsp_error=0, rsp_timeout=0.
REQ-038 calc_done never asserted, TIMEOUT=15 -> entry {timeout=1,error=1,data=8'h00} appears; busy high for 18 cycles (ISSUE + 16 WAIT + STORE).
REQ-039 f=0..7 issued back-to-back with rsp_ready=0 -> exactly 4 accepted; cmd_ready=0 until one pop; later pops return results in order.
REQ-040 With FIFO count 3, a STORE push and an rsp_ready pop in the same cycle -> count stays 3, and the head advances correctly.
REQ-041 calc model sets calc_error=1 with done, and a separate case with done asserted exactly at timer==TIMEOUT -> rsp_error=1, rsp_timeout=0 in both cases.
REQ-042 rst pulsed low mid-WAIT, then a late calc_done -> no response is produced, all outputs are 0 during reset, and the next command completes normally.

Source files
------------

// File: rtl/calc_driver_if.sv
// rtl/calc_driver_if.sv - host command, calculator and response signals of calc_driver
interface calc_driver_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_f;
    logic [3:0] cmd_x;
    logic [3:0] cmd_y;
    logic       calc_go;
    logic [2:0] calc_f;
    logic [3:0] calc_x;
    logic [3:0] calc_y;
    logic       calc_done;
    logic       calc_error;
    logic [3:0] calc_out_h;
    logic [3:0] calc_out_l;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       rsp_error;
    logic       rsp_timeout;
    logic       busy;

    modport slave (
        input  cmd_valid, cmd_f, cmd_x, cmd_y,
        input  calc_done, calc_error, calc_out_h, calc_out_l,
        input  rsp_ready,
        output cmd_ready, calc_go, calc_f, calc_x, calc_y,
        output rsp_valid, rsp_data, rsp_error, rsp_timeout, busy
    );

    modport master (
        output cmd_valid, cmd_f, cmd_x, cmd_y,
        output calc_done, calc_error, calc_out_h, calc_out_l,
        output rsp_ready,
        input  cmd_ready, calc_go, calc_f, calc_x, calc_y,
        input  rsp_valid, rsp_data, rsp_error, rsp_timeout, busy
    );
endinterface

// File: rtl/calc_driver.sv
// rtl/calc_driver.sv - issues host commands to a calculator one at a time, queues results in a 4-deep FIFO
module calc_driver #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    calc_driver_if.slave  bus
);
    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [3:0]      x_q, x_d, y_q, y_d;
    logic [2:0]      f_q, f_d;
    logic [9:0]      ent_q, ent_d;
    logic [9:0]      mem [4];
    logic [1:0]      wr_q, rd_q;
    logic [2:0]      cnt_q, cnt_d;
    logic            ready, go, push, pop;
    logic [9:0]      head;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        x_d     = x_q;
        y_d     = y_q;
        f_d     = f_q;
        ent_d   = ent_q;
        ready   = 1'b0;
        go      = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by rst_ni so cmd_ready reads 0 while reset is held.
                ready = rst_ni && (cnt_q < 3'd4);
                if (bus.cmd_valid && ready) begin
                    x_d     = bus.cmd_x;
                    y_d     = bus.cmd_y;
                    f_d     = bus.cmd_f;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                go      = 1'b1;
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.calc_done) begin
                    ent_d   = {1'b0, bus.calc_error, bus.calc_out_h, bus.calc_out_l};
                    state_d = STORE;
                end else if (timer_q == TMAX) begin
                    ent_d   = {1'b1, 1'b1, 8'h00};
                    state_d = STORE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STORE: begin
                push    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop = (cnt_q != 3'd0) && bus.rsp_ready;

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            timer_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            f_q     <= '0;
            ent_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            x_q     <= x_d;
            y_q     <= y_d;
            f_q     <= f_d;
            ent_q   <= ent_d;
            cnt_q   <= cnt_d;
            if (push) wr_q <= wr_q + 2'd1;
            if (pop)  rd_q <= rd_q + 2'd1;
        end
    end

    // Storage needs no reset: outputs are masked whenever the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_q] <= ent_q;
    end

    assign head            = mem[rd_q];
    assign bus.cmd_ready   = ready;
    assign bus.calc_go     = go;
    assign bus.calc_x      = x_q;
    assign bus.calc_y      = y_q;
    assign bus.calc_f      = f_q;
    assign bus.rsp_valid   = (cnt_q != 3'd0);
    assign bus.rsp_data    = bus.rsp_valid ? head[7:0] : 8'h00;
    assign bus.rsp_error   = bus.rsp_valid & head[8];
    assign bus.rsp_timeout = bus.rsp_valid & head[9];
    assign bus.busy        = (state_q != IDLE);
endmodule
